// File: rtl/trng_ro_sampler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trng_ro_sampler: ring-oscillator sampler with debias, health test, packer |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module trng_ro_sampler #(
    parameter int NUM_RO      = 4,
    parameter int OUT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int SAMPLE_DIV  = 4,
    parameter int REP_LIMIT   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_RO-1:0] ro_in,
    output logic [NUM_RO-1:0] ro_en,
    input  logic              enable,
    input  logic              debias_en,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              health_fail
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int REP_W = $clog2(REP_LIMIT + 1);
    localparam int CNT_W = $clog2(OUT_W + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [REP_W-1:0] REP_MAX  = REP_W'(REP_LIMIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUT_W);

    logic [NUM_RO-1:0] sync_q [SYNC_STAGES];
    logic [NUM_RO-1:0] sync_d [SYNC_STAGES];
    logic [DIV_W-1:0]  div_q, div_d;
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic              prev_q, prev_d;
    logic              pair_q, pair_d;
    logic              first_q, first_d;
    logic [OUT_W-1:0]  sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              health_fail_q, health_fail_d;

    logic              strobe;
    logic              raw_bit;
    logic              acc_valid;
    logic              acc_bit;
    logic              full;
    logic              load;
    logic [CNT_W-1:0]  cnt_base;

    always_comb begin
        sync_d[0] = ro_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_comb begin
        strobe  = enable & ~health_fail_q & (div_q == DIV_LAST);
        raw_bit = ^sync_q[SYNC_STAGES-1];

        div_d = div_q;
        if (!enable || health_fail_q) begin
            div_d = '0;
        end else if (div_q == DIV_LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        // A zero count means no previous raw bit since enable rose.
        rep_cnt_d = rep_cnt_q;
        prev_d    = prev_q;
        if (!enable) begin
            rep_cnt_d = '0;
        end else if (strobe) begin
            prev_d = raw_bit;
            if (rep_cnt_q == '0 || raw_bit != prev_q) begin
                rep_cnt_d = REP_W'(1);
            end else if (rep_cnt_q != REP_MAX) begin
                rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
        end
        health_fail_d = health_fail_q | (strobe & (rep_cnt_d == REP_MAX));

        acc_valid = 1'b0;
        acc_bit   = raw_bit;
        pair_d    = pair_q;
        first_d   = first_q;
        if (strobe) begin
            if (!debias_en) begin
                acc_valid = 1'b1;
            end else if (!pair_q) begin
                pair_d  = 1'b1;
                first_d = raw_bit;
            end else begin
                pair_d    = 1'b0;
                acc_valid = first_q ^ raw_bit;
                acc_bit   = first_q;
            end
        end

        // A full packer hands over when the output register frees up this edge.
        full     = enable & (cnt_q == CNT_FULL);
        load     = full & (~out_valid_q | out_ready);
        cnt_base = load ? '0 : cnt_q;
        sr_d     = sr_q;
        cnt_d    = cnt_base;
        if (acc_valid && !(full && !load)) begin
            sr_d  = {sr_q[OUT_W-2:0], acc_bit};
            cnt_d = cnt_base + CNT_W'(1);
        end

        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (load) begin
            out_data_d  = sr_q;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (!enable) begin
            cnt_d  = '0;
            pair_d = 1'b0;
        end
        if (health_fail_d) begin
            cnt_d       = '0;
            sr_d        = '0;
            pair_d      = 1'b0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            div_q         <= '0;
            rep_cnt_q     <= '0;
            prev_q        <= 1'b0;
            pair_q        <= 1'b0;
            first_q       <= 1'b0;
            sr_q          <= '0;
            cnt_q         <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            health_fail_q <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            div_q         <= div_d;
            rep_cnt_q     <= rep_cnt_d;
            prev_q        <= prev_d;
            pair_q        <= pair_d;
            first_q       <= first_d;
            sr_q          <= sr_d;
            cnt_q         <= cnt_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            health_fail_q <= health_fail_d;
        end
    end

    // Oscillators stay off while reset is held, whatever enable says.
    assign ro_en       = {NUM_RO{enable & ~health_fail_q & rst_n}};
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign health_fail = health_fail_q;

endmodule
`default_nettype wire

// File: tb/tb_trng_ro_sampler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_trng_ro_sampler: directed self-checking bench for trng_ro_sampler      |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_trng_ro_sampler;

    logic       clk;
    logic       rst_n;
    logic [3:0] ro_in;
    logic [3:0] ro_en;
    logic       enable;
    logic       debias_en;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       health_fail;

    int n_total;
    int n_bad;

    trng_ro_sampler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ro_in       (ro_in),
        .ro_en       (ro_en),
        .enable      (enable),
        .debias_en   (debias_en),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .health_fail (health_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Vary every oscillator line while fixing the parity to the wanted raw bit.
    function automatic logic [3:0] mk_ro(input logic b, input int k);
        logic [3:0] v;
        v[2:0] = k[2:0];
        v[3]   = b ^ (^v[2:0]);
        return v;
    endfunction

    // Called at a negedge; one raw bit per 4-cycle strobe period, MSB of bits first.
    task automatic run_bits(input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ro_in  = mk_ro(bits[n-1-i], i);
            enable = 1'b1;
            tick(4);
        end
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        enable    = 1'b1;
        debias_en = 1'b0;
        out_ready = 1'b0;
        ro_in     = 4'h0;

        tick(3);
        chk("reset_ro_en", {28'd0, ro_en}, 32'h0);
        chk("reset_valid", {31'd0, out_valid}, 32'h0);
        chk("reset_hfail", {31'd0, health_fail}, 32'h0);
        chk("reset_data", {24'd0, out_data}, 32'h0);
        rst_n = 1'b1;
        tick(1);
        chk("post_reset_ro_en", {28'd0, ro_en}, 32'hF);
        enable = 1'b0;
        tick(3);

        // Plain packing, first bit lands in the MSB
        run_bits(32'hB2, 8);
        chk("b2_valid_early", {31'd0, out_valid}, 32'h0);
        tick(1);
        chk("b2_valid", {31'd0, out_valid}, 32'h1);
        chk("b2_data", {24'd0, out_data}, 32'hB2);
        out_ready = 1'b1;
        tick(1);
        chk("b2_drained", {31'd0, out_valid}, 32'h0);
        out_ready = 1'b0;
        enable    = 1'b0;
        tick(3);

        // Von Neumann debiasing
        debias_en = 1'b1;
        tick(1);
        run_bits(32'h78969, 20);
        chk("vn_valid_early", {31'd0, out_valid}, 32'h0);
        tick(1);
        chk("vn_valid", {31'd0, out_valid}, 32'h1);
        chk("vn_data", {24'd0, out_data}, 32'h66);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        enable    = 1'b0;
        tick(1);
        debias_en = 1'b0;
        tick(3);

        // Backpressure: 20 words offered, output held, one word parked in the packer
        run_bits(32'hAAAAAAAA, 32);
        chk("bp_valid_1", {31'd0, out_valid}, 32'h1);
        chk("bp_data_1", {24'd0, out_data}, 32'hAA);
        for (int w = 0; w < 4; w++) begin
            run_bits(32'hAAAAAAAA, 32);
        end
        chk("bp_valid_2", {31'd0, out_valid}, 32'h1);
        chk("bp_data_2", {24'd0, out_data}, 32'hAA);
        out_ready = 1'b1;
        tick(1);
        chk("bp_refill_valid", {31'd0, out_valid}, 32'h1);
        chk("bp_refill_data", {24'd0, out_data}, 32'hAA);
        tick(1);
        chk("bp_dropped", {31'd0, out_valid}, 32'h0);
        out_ready = 1'b0;
        enable    = 1'b0;
        tick(3);

        // Partial word discarded by enable drop
        run_bits(32'h13, 5);
        enable = 1'b0;
        tick(3);
        run_bits(32'h5C, 8);
        tick(1);
        chk("partial_valid", {31'd0, out_valid}, 32'h1);
        chk("partial_data", {24'd0, out_data}, 32'h5C);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        enable    = 1'b0;
        tick(3);

        // Repetition-count health test
        run_bits(32'hFFFF, 15);
        ro_in = mk_ro(1'b1, 15);
        tick(3);
        chk("rep_hfail_early", {31'd0, health_fail}, 32'h0);
        chk("rep_valid_before", {31'd0, out_valid}, 32'h1);
        tick(1);
        chk("rep_hfail", {31'd0, health_fail}, 32'h1);
        chk("rep_ro_en", {28'd0, ro_en}, 32'h0);
        chk("rep_valid_cleared", {31'd0, out_valid}, 32'h0);
        enable = 1'b0;
        tick(3);
        enable = 1'b1;
        tick(3);
        chk("rep_sticky", {31'd0, health_fail}, 32'h1);
        chk("rep_sticky_ro_en", {28'd0, ro_en}, 32'h0);
        rst_n = 1'b0;
        tick(2);
        chk("rep_reset_hfail", {31'd0, health_fail}, 32'h0);
        rst_n = 1'b1;
        tick(1);
        chk("rep_reset_ro_en", {28'd0, ro_en}, 32'hF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
